// File: rtl/decode_execute_register.sv
// Decode->execute pipeline register with stall/flush, valid tracking and zero-register write suppression.
// Optional performance counters (StallCountE/BubbleCountE) are built when DE_REG_PERF_EN is defined.
module decode_execute_register #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         StallE,
    input  logic         FlushE,
    input  logic         ValidD,
    input  logic [N-1:0] RD1D,
    input  logic [N-1:0] RD2D,
    input  logic [N-1:0] ExtImmD,
    input  logic [N-1:0] PCPlus8D,
    input  logic [4:0]   RA1D,
    input  logic [4:0]   RA2D,
    input  logic [4:0]   WA3D,
    input  logic         RegWriteD,
    input  logic         MemWriteD,
    input  logic         MemtoRegD,
    input  logic         ALUSrcD,
    input  logic         BranchD,
    input  logic [3:0]   ALUControlD,
    input  logic [1:0]   FlagWriteD,
    input  logic [3:0]   CondD,
    output logic [N-1:0] RD1E,
    output logic [N-1:0] RD2E,
    output logic [N-1:0] ExtImmE,
    output logic [N-1:0] PCPlus8E,
    output logic [4:0]   RA1E,
    output logic [4:0]   RA2E,
    output logic [4:0]   WA3E,
    output logic         RegWriteE,
    output logic         MemWriteE,
    output logic         MemtoRegE,
    output logic         ALUSrcE,
    output logic         BranchE,
    output logic [3:0]   ALUControlE,
    output logic [1:0]   FlagWriteE,
    output logic [3:0]   CondE,
`ifdef DE_REG_PERF_EN
    output logic [15:0]  StallCountE,
    output logic [15:0]  BubbleCountE,
`endif
    output logic         ValidE
);

    typedef struct packed {
        logic         valid;
        logic         regwrite;
        logic         memwrite;
        logic         memtoreg;
        logic         alusrc;
        logic         branch;
        logic [3:0]   aluctl;
        logic [1:0]   flagwrite;
        logic [3:0]   cond;
        logic [N-1:0] rd1;
        logic [N-1:0] rd2;
        logic [N-1:0] extimm;
        logic [N-1:0] pcplus8;
        logic [4:0]   ra1;
        logic [4:0]   ra2;
        logic [4:0]   wa3;
    } stage_t;

    stage_t stage_q, stage_d;
    logic   bubble_wr;

    // A bubble is written on flush, or on a plain load of an invalid decode slot.
    assign bubble_wr = FlushE || (!StallE && !ValidD);

    always_comb begin
        stage_d = stage_q;
        if (bubble_wr) begin
            stage_d = '0;
        end else if (!StallE) begin
            stage_d.valid     = 1'b1;
            stage_d.regwrite  = RegWriteD && (WA3D != 5'd0);
            stage_d.memwrite  = MemWriteD;
            stage_d.memtoreg  = MemtoRegD;
            stage_d.alusrc    = ALUSrcD;
            stage_d.branch    = BranchD;
            stage_d.aluctl    = ALUControlD;
            stage_d.flagwrite = FlagWriteD;
            stage_d.cond      = CondD;
            stage_d.rd1       = RD1D;
            stage_d.rd2       = RD2D;
            stage_d.extimm    = ExtImmD;
            stage_d.pcplus8   = PCPlus8D;
            stage_d.ra1       = RA1D;
            stage_d.ra2       = RA2D;
            stage_d.wa3       = WA3D;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign ValidE      = stage_q.valid;
    assign RegWriteE   = stage_q.regwrite;
    assign MemWriteE   = stage_q.memwrite;
    assign MemtoRegE   = stage_q.memtoreg;
    assign ALUSrcE     = stage_q.alusrc;
    assign BranchE     = stage_q.branch;
    assign ALUControlE = stage_q.aluctl;
    assign FlagWriteE  = stage_q.flagwrite;
    assign CondE       = stage_q.cond;
    assign RD1E        = stage_q.rd1;
    assign RD2E        = stage_q.rd2;
    assign ExtImmE     = stage_q.extimm;
    assign PCPlus8E    = stage_q.pcplus8;
    assign RA1E        = stage_q.ra1;
    assign RA2E        = stage_q.ra2;
    assign WA3E        = stage_q.wa3;

`ifdef DE_REG_PERF_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (StallE && !FlushE) stall_cnt_d = sat_inc(stall_cnt_q);
        if (bubble_wr)         bubble_cnt_d = sat_inc(bubble_cnt_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign StallCountE  = stall_cnt_q;
    assign BubbleCountE = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_decode_execute_register.sv
// Directed self-checking bench for decode_execute_register (counter tests run when DE_REG_PERF_EN is defined).
module tb_decode_execute_register;

    logic        clk = 1'b0;
    logic        rst, StallE, FlushE, ValidD;
    logic [31:0] RD1D, RD2D, ExtImmD, PCPlus8D;
    logic [4:0]  RA1D, RA2D, WA3D;
    logic        RegWriteD, MemWriteD, MemtoRegD, ALUSrcD, BranchD;
    logic [3:0]  ALUControlD, CondD;
    logic [1:0]  FlagWriteD;
    logic [31:0] RD1E, RD2E, ExtImmE, PCPlus8E;
    logic [4:0]  RA1E, RA2E, WA3E;
    logic        RegWriteE, MemWriteE, MemtoRegE, ALUSrcE, BranchE, ValidE;
    logic [3:0]  ALUControlE, CondE;
    logic [1:0]  FlagWriteE;
`ifdef DE_REG_PERF_EN
    logic [15:0] StallCountE, BubbleCountE;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    decode_execute_register #(.N(32)) dut (
        .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
        .RD1D(RD1D), .RD2D(RD2D), .ExtImmD(ExtImmD), .PCPlus8D(PCPlus8D),
        .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .MemtoRegD(MemtoRegD),
        .ALUSrcD(ALUSrcD), .BranchD(BranchD), .ALUControlD(ALUControlD),
        .FlagWriteD(FlagWriteD), .CondD(CondD),
        .RD1E(RD1E), .RD2E(RD2E), .ExtImmE(ExtImmE), .PCPlus8E(PCPlus8E),
        .RA1E(RA1E), .RA2E(RA2E), .WA3E(WA3E),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE),
        .ALUSrcE(ALUSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
        .FlagWriteE(FlagWriteE), .CondE(CondE),
`ifdef DE_REG_PERF_EN
        .StallCountE(StallCountE), .BubbleCountE(BubbleCountE),
`endif
        .ValidE(ValidE)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all_d(input logic [31:0] seed);
        RD1D = seed; RD2D = ~seed; ExtImmD = seed ^ 32'h0F0F0F0F; PCPlus8D = seed + 32'd8;
        RA1D = seed[4:0]; RA2D = seed[9:5]; WA3D = 5'd7;
        RegWriteD = 1'b1; MemWriteD = 1'b1; MemtoRegD = 1'b1; ALUSrcD = 1'b1; BranchD = 1'b1;
        ALUControlD = 4'hA; FlagWriteD = 2'b11; CondD = 4'hE; ValidD = 1'b1;
    endtask

    task automatic test_reset();
        StallE = 1'b0; FlushE = 1'b0;
        set_all_d(32'hCAFEBABE);
        rst = 1'b1;
        tick();
        total++; if (ValidE !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", ValidE); end
        total++; if (RD1E !== 32'h0) begin bad++; $display("FAIL reset_rd1 got %h want 0", RD1E); end
        total++; if (RegWriteE !== 1'b0) begin bad++; $display("FAIL reset_regwrite got %b want 0", RegWriteE); end
        total++; if ({PCPlus8E, CondE, ALUControlE, WA3E} !== 45'h0) begin
            bad++; $display("FAIL reset_misc got %h want 0", {PCPlus8E, CondE, ALUControlE, WA3E}); end
        rst = 1'b0;
        ValidD = 1'b1; RD1D = 32'h12345678; WA3D = 5'd4; RegWriteD = 1'b1;
        tick();
        total++; if (RD1E !== 32'h12345678) begin bad++; $display("FAIL first_rd1 got %h want 12345678", RD1E); end
        total++; if (WA3E !== 5'd4) begin bad++; $display("FAIL first_wa3 got %0d want 4", WA3E); end
        total++; if (RegWriteE !== 1'b1) begin bad++; $display("FAIL first_regwrite got %b want 1", RegWriteE); end
        total++; if (ValidE !== 1'b1) begin bad++; $display("FAIL first_valid got %b want 1", ValidE); end
    endtask

    task automatic test_load_fields();
        RD1D = 32'h11111111; RD2D = 32'h22222222; ExtImmD = 32'hFFFFFF80; PCPlus8D = 32'h00001008;
        RA1D = 5'h13; RA2D = 5'h02; WA3D = 5'h1F;
        RegWriteD = 1'b1; MemWriteD = 1'b0; MemtoRegD = 1'b1; ALUSrcD = 1'b1; BranchD = 1'b0;
        ALUControlD = 4'h9; FlagWriteD = 2'b10; CondD = 4'h1; ValidD = 1'b1;
        tick();
        total++; if ({RD2E, ExtImmE, PCPlus8E} !== {32'h22222222, 32'hFFFFFF80, 32'h00001008}) begin
            bad++; $display("FAIL load_data got %h want 22222222ffffff8000001008", {RD2E, ExtImmE, PCPlus8E}); end
        total++; if ({RA1E, RA2E, WA3E} !== {5'h13, 5'h02, 5'h1F}) begin
            bad++; $display("FAIL load_addr got %h want %h", {RA1E, RA2E, WA3E}, {5'h13, 5'h02, 5'h1F}); end
        total++; if ({RegWriteE, MemWriteE, MemtoRegE, ALUSrcE, BranchE} !== 5'b10110) begin
            bad++; $display("FAIL load_ctrl got %b want 10110", {RegWriteE, MemWriteE, MemtoRegE, ALUSrcE, BranchE}); end
        total++; if ({ALUControlE, FlagWriteE, CondE} !== {4'h9, 2'b10, 4'h1}) begin
            bad++; $display("FAIL load_ops got %h want %h", {ALUControlE, FlagWriteE, CondE}, {4'h9, 2'b10, 4'h1}); end
    endtask

    task automatic test_stall();
        set_all_d(32'h0);
        RD2D = 32'hA5A5A5A5;
        tick();
        total++; if (RD2E !== 32'hA5A5A5A5) begin bad++; $display("FAIL stall_preload got %h want a5a5a5a5", RD2E); end
        StallE = 1'b1; RD2D = 32'hFFFFFFFF; ValidD = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (RD2E !== 32'hA5A5A5A5 || ValidE !== 1'b1) begin
                bad++; $display("FAIL stall_hold%0d got rd2=%h valid=%b want a5a5a5a5/1", i, RD2E, ValidE); end
        end
        StallE = 1'b0; ValidD = 1'b1;
        tick();
        total++; if (RD2E !== 32'hFFFFFFFF) begin bad++; $display("FAIL stall_release got %h want ffffffff", RD2E); end
    endtask

    task automatic test_flush_vs_stall();
        set_all_d(32'h55AA55AA);
        tick();
        StallE = 1'b1; FlushE = 1'b1; MemWriteD = 1'b1;
        tick();
        total++; if ({ValidE, MemWriteE} !== 2'b00) begin
            bad++; $display("FAIL flush_ctrl got %b want 00", {ValidE, MemWriteE}); end
        total++; if (RD1E !== 32'h0 || PCPlus8E !== 32'h0 || WA3E !== 5'd0) begin
            bad++; $display("FAIL flush_data got rd1=%h pc=%h wa3=%h want 0", RD1E, PCPlus8E, WA3E); end
        StallE = 1'b0; FlushE = 1'b0;
    endtask

    task automatic test_zero_reg();
        set_all_d(32'h0BADF00D);
        RegWriteD = 1'b1; WA3D = 5'd0; ALUControlD = 4'h3;
        tick();
        total++; if ({RegWriteE, ALUControlE, ValidE} !== {1'b0, 4'h3, 1'b1}) begin
            bad++; $display("FAIL zero_reg got rw=%b alu=%h v=%b want 0/3/1", RegWriteE, ALUControlE, ValidE); end
        WA3D = 5'd16;
        tick();
        total++; if (RegWriteE !== 1'b1 || WA3E !== 5'd16) begin
            bad++; $display("FAIL vec_reg got rw=%b wa3=%h want 1/10", RegWriteE, WA3E); end
    endtask

    task automatic test_invalid();
        set_all_d(32'h0);
        ValidD = 1'b0; BranchD = 1'b1; RD1D = 32'hDE000;
        tick();
        total++; if ({BranchE, ValidE, MemWriteE, FlagWriteE} !== 5'b0) begin
            bad++; $display("FAIL invalid_ctrl got %b want 00000", {BranchE, ValidE, MemWriteE, FlagWriteE}); end
        total++; if (RD1E !== 32'h0) begin bad++; $display("FAIL invalid_rd1 got %h want 0", RD1E); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [3];
        vals[0] = 32'h00000001; vals[1] = 32'h80000000; vals[2] = 32'h7FFFFFFF;
        set_all_d(32'h0);
        for (int i = 0; i < 3; i++) begin
            RD1D = vals[i]; ExtImmD = ~vals[i];
            tick();
            total++; if (RD1E !== vals[i] || ExtImmE !== ~vals[i]) begin
                bad++; $display("FAIL b2b%0d got %h/%h want %h/%h", i, RD1E, ExtImmE, vals[i], ~vals[i]); end
        end
    endtask

`ifdef DE_REG_PERF_EN
    task automatic test_perf();
        rst = 1'b1; tick(); rst = 1'b0;
        total++; if ({StallCountE, BubbleCountE} !== 32'h0) begin
            bad++; $display("FAIL perf_reset got %h want 0", {StallCountE, BubbleCountE}); end
        set_all_d(32'h1);
        StallE = 1'b1;
        repeat (5) tick();
        StallE = 1'b0; FlushE = 1'b1;
        repeat (2) tick();
        FlushE = 1'b0;
        total++; if (StallCountE !== 16'd5 || BubbleCountE !== 16'd2) begin
            bad++; $display("FAIL perf_counts got s=%0d b=%0d want 5/2", StallCountE, BubbleCountE); end
        ValidD = 1'b0; tick(); ValidD = 1'b1;
        total++; if (BubbleCountE !== 16'd3) begin bad++; $display("FAIL perf_invalid got %0d want 3", BubbleCountE); end
        StallE = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        StallE = 1'b0;
        total++; if (StallCountE !== 16'hFFFF) begin bad++; $display("FAIL perf_sat got %h want ffff", StallCountE); end
    endtask
`endif

    initial begin
        rst = 1'b0; StallE = 1'b0; FlushE = 1'b0;
        set_all_d(32'h0);
        test_reset();
        test_load_fields();
        test_stall();
        test_flush_vs_stall();
        test_zero_reg();
        test_invalid();
        test_back_to_back();
`ifdef DE_REG_PERF_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
